// File: rtl/operand_entry.sv
// operand_entry: button-driven front end for the 4-bit add/sub ALU.
// Synchronizes and debounces the confirm button, then walks a three-stage
// entry sequence (A0, A1 + op select, SHOW) that latches the switch values.
module operand_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned WIDTH           = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_val,
    input  logic             sw_op,
    input  logic             btn_n,
    output logic [WIDTH-1:0] a0,
    output logic [WIDTH-1:0] a1,
    output logic             s,
    output logic             valid,
    output logic             done,
    output logic [1:0]       stage
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ENTER_A0 = 2'd0,
        ENTER_A1 = 2'd1,
        SHOW     = 2'd2,
        UNUSED   = 2'd3
    } state_e;

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_c;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a0_q, a0_d;
    logic [WIDTH-1:0] a1_q, a1_d;
    logic             s_q, s_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    // Two-flop synchronizer for the asynchronous button; idles released (1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a new level must persist DEBOUNCE_CYCLES cycles; counter saturates by clearing.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Press event fires in the cycle the debounced level is about to fall.
    assign press_c = db_q & ~db_d;

    // Debouncer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q  <= 1'b1;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry FSM next-state and registered-output logic; advances only on a press.
    always_comb begin
        state_d = state_q;
        a0_d    = a0_q;
        a1_d    = a1_q;
        s_d     = s_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        unique case (state_q)
            ENTER_A0: begin
                if (press_c) begin
                    a0_d    = sw_val;
                    state_d = ENTER_A1;
                end
            end
            ENTER_A1: begin
                if (press_c) begin
                    a1_d    = sw_val;
                    s_d     = sw_op;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (press_c) begin
                    valid_d = 1'b0;
                    state_d = ENTER_A0;
                end
            end
            default: begin
                state_d = ENTER_A0;
            end
        endcase
    end

    // FSM state and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENTER_A0;
            a0_q    <= '0;
            a1_q    <= '0;
            s_q     <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            s_q     <= s_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign a0    = a0_q;
    assign a1    = a1_q;
    assign s     = s_q;
    assign valid = valid_q;
    assign done  = done_q;
    assign stage = 2'(state_q);

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a short debounce window.
module tb_operand_entry;

    localparam int unsigned DB = 4;
    localparam int unsigned W  = 4;

    typedef struct packed {
        logic [W-1:0] a0;
        logic [W-1:0] a1;
        logic         s;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] sw_val;
    logic         sw_op;
    logic         btn_n;
    logic [W-1:0] a0;
    logic [W-1:0] a1;
    logic         s;
    logic         valid;
    logic         done;
    logic [1:0]   stage;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   trans    = 0;
    int   trans_cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic [1:0] prev_stage = 2'd0;

    operand_entry #(.DEBOUNCE_CYCLES(DB), .WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_val (sw_val),
        .sw_op  (sw_op),
        .btn_n  (btn_n),
        .a0     (a0),
        .a1     (a1),
        .s      (s),
        .valid  (valid),
        .done   (done),
        .stage  (stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; watch stage changes and pop the scoreboard on each done pulse.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (stage !== prev_stage) begin
            trans++;
            trans_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_from_a1", 32'(prev_stage), 32'd1);
            check("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_a0", 32'(a0), 32'(e.a0));
                check("sb_a1", 32'(a1), 32'(e.a1));
                check("sb_s", 32'(s), 32'(e.s));
                check("sb_valid", 32'(valid), 32'd1);
                check("sb_stage", 32'(stage), 32'd2);
            end
        end
        prev_stage = stage;
    endtask

    task automatic clear_stats();
        cyc = 0;
        trans = 0;
        trans_cyc = 0;
        done_cnt = 0;
        done_cyc = 0;
    endtask

    task automatic press(input int lo, input int hi);
        clear_stats();
        btn_n = 1'b0;
        repeat (lo) step();
        btn_n = 1'b1;
        repeat (hi) step();
    endtask

    initial begin
        rst_n  = 1'b0;
        btn_n  = 1'b1;
        sw_val = '0;
        sw_op  = 1'b0;
        #12;
        check("rst_a0", 32'(a0), 32'd0);
        check("rst_a1", 32'(a1), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stage", 32'(stage), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step();

        // Full sequence: A0 = 7, then A1 = 3 with subtract.
        sw_val = 4'h7;
        sw_op  = 1'b0;
        press(10, 10);
        check("seq1_trans", 32'(trans), 32'd1);
        check("seq1_stage", 32'(stage), 32'd1);
        check("seq1_a0", 32'(a0), 32'h7);
        check("seq1_valid", 32'(valid), 32'd0);
        check("seq1_done_cnt", 32'(done_cnt), 32'd0);
        sw_val = 4'h3;
        sw_op  = 1'b1;
        sb.push_back('{a0: 4'h7, a1: 4'h3, s: 1'b1});
        press(10, 10);
        check("seq2_done_cnt", 32'(done_cnt), 32'd1);
        check("seq2_done_latency", 32'(done_cyc), 32'(2 + DB));
        check("seq2_stage", 32'(stage), 32'd2);
        check("seq2_valid", 32'(valid), 32'd1);
        check("seq2_done_low", 32'(done), 32'd0);

        // Wrap: press in SHOW returns to ENTER_A0 keeping operands.
        press(10, 10);
        check("wrap_stage", 32'(stage), 32'd0);
        check("wrap_valid", 32'(valid), 32'd0);
        check("wrap_a0", 32'(a0), 32'h7);
        check("wrap_a1", 32'(a1), 32'h3);
        check("wrap_s", 32'(s), 32'd1);

        // Bounce: 3 low, 2 high, 3 low, then release; no event.
        sw_val = 4'h2;
        clear_stats();
        btn_n = 1'b0;
        repeat (3) step();
        btn_n = 1'b1;
        repeat (2) step();
        btn_n = 1'b0;
        repeat (3) step();
        btn_n = 1'b1;
        repeat (10) step();
        check("bounce_trans", 32'(trans), 32'd0);
        check("bounce_stage", 32'(stage), 32'd0);
        check("bounce_a0", 32'(a0), 32'h7);

        // Clean 10-cycle press after bounce gives exactly one event.
        press(10, 10);
        check("clean_trans", 32'(trans), 32'd1);
        check("clean_stage", 32'(stage), 32'd1);
        check("clean_a0", 32'(a0), 32'h2);

        // Switch change without a press has no effect.
        sw_val = 4'h9;
        clear_stats();
        repeat (5) step();
        check("iso_a0", 32'(a0), 32'h2);
        check("iso_a1", 32'(a1), 32'h3);
        check("iso_stage", 32'(stage), 32'd1);

        // Hold for 100 cycles; switches change after the press cycle.
        sw_val = 4'h4;
        sw_op  = 1'b0;
        sb.push_back('{a0: 4'h2, a1: 4'h4, s: 1'b0});
        clear_stats();
        btn_n = 1'b0;
        repeat (8) step();
        sw_val = 4'hF;
        sw_op  = 1'b1;
        repeat (92) step();
        btn_n = 1'b1;
        repeat (20) step();
        check("hold_trans", 32'(trans), 32'd1);
        check("hold_done_cnt", 32'(done_cnt), 32'd1);
        check("hold_a1", 32'(a1), 32'h4);
        check("hold_s", 32'(s), 32'd0);
        check("hold_a0", 32'(a0), 32'h2);

        // Wrap then overwrite only A0.
        sw_val = 4'hA;
        press(10, 10);
        check("wrap2_stage", 32'(stage), 32'd0);
        check("wrap2_a0", 32'(a0), 32'h2);
        press(10, 10);
        check("ovr_stage", 32'(stage), 32'd1);
        check("ovr_a0", 32'(a0), 32'hA);
        check("ovr_a1", 32'(a1), 32'h4);
        check("ovr_s", 32'(s), 32'd0);

        // Build a SHOW state with A0 = 5.
        sw_op = 1'b0;
        sb.push_back('{a0: 4'hA, a1: 4'hA, s: 1'b0});
        press(10, 10);
        press(10, 10);
        sw_val = 4'h5;
        press(10, 10);
        sw_val = 4'h6;
        sb.push_back('{a0: 4'h5, a1: 4'h6, s: 1'b0});
        press(10, 10);
        check("pre_rst_stage", 32'(stage), 32'd2);
        check("pre_rst_a0", 32'(a0), 32'h5);

        // Async reset mid-SHOW with a press in progress.
        btn_n = 1'b0;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_a0", 32'(a0), 32'd0);
        check("mid_rst_a1", 32'(a1), 32'd0);
        check("mid_rst_s", 32'(s), 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_stage", 32'(stage), 32'd0);
        prev_stage = 2'd0;
        repeat (2) step();
        rst_n = 1'b1;
        clear_stats();
        repeat (10) step();
        check("redeb_trans", 32'(trans), 32'd1);
        check("redeb_latency", 32'(trans_cyc), 32'(2 + DB));
        check("redeb_a0", 32'(a0), 32'h6);
        btn_n = 1'b1;
        repeat (10) step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
